// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the program counter, holds a word-aligned
// address to a combinational instruction memory for MEM_WAIT edges, captures
// the returned word into a one-entry buffer and hands it to decode over a
// valid/ready handshake. Taken branches/jumps redirect the PC, and a
// misaligned redirect target parks the unit in a sticky fault state.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_addr
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        FAULT = 2'd2
    } state_t;

    // Count value on which the memory word is considered settled.
    localparam logic [3:0] CNT_LAST = 4'(MEM_WAIT - 1);

    state_t      state;
    logic [31:0] pc;
    logic [3:0]  cnt;
    logic        buf_free;

    // The buffer can take a new word if it is empty or is being drained now.
    assign buf_free  = !instr_valid || instr_ready;

    // The PC register is the memory address; no logic in between.
    assign imem_addr = pc;

    // Fetch FSM: wait counting, buffer capture/handshake, redirect and fault.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            cnt         <= 4'd0;
            instr_valid <= 1'b0;
            instr       <= 32'h0;
            instr_pc    <= 32'h0;
            fetch_fault <= 1'b0;
            fault_addr  <= 32'h0;
        end else if (redirect_valid) begin
            // A redirect always flushes the buffer; any capture due is dropped.
            instr_valid <= 1'b0;
            cnt         <= 4'd0;
            if (redirect_pc[1:0] == 2'b00) begin
                pc          <= redirect_pc;
                fetch_fault <= 1'b0;
                state       <= FETCH;
            end else begin
                fetch_fault <= 1'b1;
                fault_addr  <= redirect_pc;
                state       <= FAULT;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (cnt == CNT_LAST) begin
                        if (buf_free) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc + 32'd4;
                            cnt         <= 4'd0;
                        end else begin
                            // Buffer full: keep the address (and thus the
                            // memory word) stable until decode drains it.
                            state <= HOLD;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                        if (instr_ready) begin
                            instr_valid <= 1'b0;
                        end
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        instr       <= imem_rdata;
                        instr_pc    <= pc;
                        instr_valid <= 1'b1;
                        pc          <= pc + 32'd4;
                        cnt         <= 4'd0;
                        state       <= FETCH;
                    end
                end
                FAULT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= FETCH;
                    cnt         <= 4'd0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: one instance with MEM_WAIT=2 driven through
// the reset/backpressure/redirect/fault/wrap scenarios with a transfer
// scoreboard, and one instance with MEM_WAIT=1 for single-cycle streaming.
module tb_instr_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instruction memory contents as a pure function of the byte address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0050_0093;
        else if (a == 32'h4) return 32'h00A0_0113;
        else                 return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    // ---------------- MEM_WAIT = 2 instance ----------------
    logic        rst0 = 1'b1;
    logic [31:0] addr0;
    logic [31:0] rdata0;
    logic        vld0;
    logic        rdy0 = 1'b0;
    logic [31:0] ins0;
    logic [31:0] ipc0;
    logic        rv0 = 1'b0;
    logic [31:0] rpc0 = 32'h0;
    logic        ff0;
    logic [31:0] fa0;

    instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WAIT(2)) dut0 (
        .clk(clk), .reset(rst0), .imem_addr(addr0), .imem_rdata(rdata0),
        .instr_valid(vld0), .instr_ready(rdy0), .instr(ins0), .instr_pc(ipc0),
        .redirect_valid(rv0), .redirect_pc(rpc0), .fetch_fault(ff0), .fault_addr(fa0)
    );

    // Memory with propagation delay: the word is only good once the address
    // has been stable across one full cycle; before that it returns garbage.
    int          age0  = 0;
    logic [31:0] last0 = 32'hxxxx_xxxx;
    always @(negedge clk) begin
        if (addr0 !== last0) age0 = 0;
        else                 age0 = age0 + 1;
        last0 = addr0;
    end
    assign rdata0 = (age0 >= 1) ? memword(addr0) : 32'hDEAD_BEEF;

    // ---------------- MEM_WAIT = 1 instance ----------------
    logic        rst1 = 1'b1;
    logic [31:0] addr1;
    logic [31:0] rdata1;
    logic        vld1;
    logic        rdy1 = 1'b0;
    logic [31:0] ins1;
    logic [31:0] ipc1;
    logic        rv1 = 1'b0;
    logic [31:0] rpc1 = 32'h0;
    logic        ff1;
    logic [31:0] fa1;

    instr_fetch_unit #(.RESET_PC(32'h0), .MEM_WAIT(1)) dut1 (
        .clk(clk), .reset(rst1), .imem_addr(addr1), .imem_rdata(rdata1),
        .instr_valid(vld1), .instr_ready(rdy1), .instr(ins1), .instr_pc(ipc1),
        .redirect_valid(rv1), .redirect_pc(rpc1), .fetch_fault(ff1), .fault_addr(fa1)
    );
    assign rdata1 = memword(addr1);

    // ---------------- scoreboard for dut0 transfers ----------------
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_ins_q[$];
    logic        watch8 = 1'b0;
    logic        seen8  = 1'b0;

    task automatic push(input logic [31:0] pc);
        exp_pc_q.push_back(pc);
        exp_ins_q.push_back(memword(pc));
    endtask

    // Inputs are stable at the falling edge, so valid&&ready here means a
    // transfer on the coming rising edge.
    always @(negedge clk) begin
        if (watch8 && vld0 && ipc0 == 32'h8) seen8 = 1'b1;
        if (!rst0 && vld0 && rdy0) begin
            total++;
            if (exp_pc_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no transfer", ipc0, ins0);
            end else begin
                logic [31:0] ep, ei;
                ep = exp_pc_q.pop_front();
                ei = exp_ins_q.pop_front();
                if (ipc0 !== ep || ins0 !== ei) begin
                    bad++;
                    $display("FAIL sb_transfer: got pc=%h instr=%h, required pc=%h instr=%h",
                             ipc0, ins0, ep, ei);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst0 = 1'b1; rdy0 = 1'b0; rv0 = 1'b0;
        tick(); tick();
        total++; if (addr0 !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h, required 0", addr0); end
        total++; if (vld0 !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b, required 0", vld0); end
        total++; if (ins0 !== 32'h0 || ipc0 !== 32'h0) begin bad++; $display("FAIL reset_buf: got instr=%h pc=%h, required 0/0", ins0, ipc0); end
        total++; if (ff0 !== 1'b0 || fa0 !== 32'h0) begin bad++; $display("FAIL reset_fault: got %b/%h, required 0/0", ff0, fa0); end
    endtask

    task automatic test_reset_fetch();
        push(32'h0);
        rdy0 = 1'b1; rst0 = 1'b0;
        tick();
        total++; if (vld0 !== 1'b0) begin bad++; $display("FAIL rf_early_valid: got %b, required 0", vld0); end
        tick();
        total++; if (vld0 !== 1'b1 || ins0 !== 32'h0050_0093 || ipc0 !== 32'h0) begin
            bad++; $display("FAIL rf_first: got v=%b instr=%h pc=%h, required 1/00500093/0", vld0, ins0, ipc0); end
        tick();
        total++; if (vld0 !== 1'b0) begin bad++; $display("FAIL rf_gap: got %b, required 0", vld0); end
        tick();
        total++; if (vld0 !== 1'b1 || ins0 !== 32'h00A0_0113 || ipc0 !== 32'h4) begin
            bad++; $display("FAIL rf_second: got v=%b instr=%h pc=%h, required 1/00a00113/4", vld0, ins0, ipc0); end
        // Mid-operation reset drops the buffered word.
        rdy0 = 1'b0; rst0 = 1'b1;
        tick();
        total++; if (vld0 !== 1'b0 || addr0 !== 32'h0) begin
            bad++; $display("FAIL rf_midreset: got v=%b addr=%h, required 0/0", vld0, addr0); end
    endtask

    task automatic test_backpressure();
        rst0 = 1'b0;
        tick(); tick();
        total++; if (vld0 !== 1'b1 || ipc0 !== 32'h0) begin
            bad++; $display("FAIL bp_first: got v=%b pc=%h, required 1/0", vld0, ipc0); end
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (vld0 !== 1'b1 || ipc0 !== 32'h0 || ins0 !== 32'h0050_0093 || addr0 !== 32'h4) begin
                bad++; $display("FAIL bp_hold: cyc %0d got v=%b pc=%h instr=%h addr=%h, required 1/0/00500093/4",
                                i, vld0, ipc0, ins0, addr0); end
        end
        push(32'h0);
        rdy0 = 1'b1;
        tick();
        total++; if (vld0 !== 1'b1 || ipc0 !== 32'h4 || ins0 !== 32'h00A0_0113) begin
            bad++; $display("FAIL bp_release: got v=%b pc=%h instr=%h, required 1/4/00a00113", vld0, ipc0, ins0); end
    endtask

    task automatic test_redirect_flush();
        rdy0 = 1'b0;
        tick();
        total++; if (vld0 !== 1'b1 || ipc0 !== 32'h4) begin
            bad++; $display("FAIL rd_setup: got v=%b pc=%h, required 1/4", vld0, ipc0); end
        push(32'h4);
        rdy0 = 1'b1; rv0 = 1'b1; rpc0 = 32'h40; watch8 = 1'b1;
        tick();
        total++; if (vld0 !== 1'b0 || addr0 !== 32'h40) begin
            bad++; $display("FAIL rd_flush: got v=%b addr=%h, required 0/40", vld0, addr0); end
        rv0 = 1'b0;
        push(32'h40);
        tick();
        total++; if (vld0 !== 1'b0) begin bad++; $display("FAIL rd_gap: got %b, required 0", vld0); end
        tick();
        total++; if (vld0 !== 1'b1 || ipc0 !== 32'h40 || ins0 !== memword(32'h40)) begin
            bad++; $display("FAIL rd_target: got v=%b pc=%h instr=%h, required 1/40/%h", vld0, ipc0, ins0, memword(32'h40)); end
    endtask

    task automatic test_misaligned();
        rv0 = 1'b1; rpc0 = 32'h42;
        tick();
        total++; if (ff0 !== 1'b1 || fa0 !== 32'h42 || vld0 !== 1'b0 || addr0 !== 32'h44) begin
            bad++; $display("FAIL ma_fault: got ff=%b fa=%h v=%b addr=%h, required 1/42/0/44", ff0, fa0, vld0, addr0); end
        rv0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (vld0 !== 1'b0 || ff0 !== 1'b1 || addr0 !== 32'h44) begin
                bad++; $display("FAIL ma_stuck: cyc %0d got v=%b ff=%b addr=%h, required 0/1/44", i, vld0, ff0, addr0); end
        end
        rv0 = 1'b1; rpc0 = 32'h81;
        tick();
        total++; if (ff0 !== 1'b1 || fa0 !== 32'h81) begin
            bad++; $display("FAIL ma_update: got ff=%b fa=%h, required 1/81", ff0, fa0); end
        rpc0 = 32'h80;
        push(32'h80);
        tick();
        total++; if (ff0 !== 1'b0 || addr0 !== 32'h80 || vld0 !== 1'b0) begin
            bad++; $display("FAIL ma_clear: got ff=%b addr=%h v=%b, required 0/80/0", ff0, addr0, vld0); end
        rv0 = 1'b0;
        tick();
        total++; if (vld0 !== 1'b0) begin bad++; $display("FAIL ma_gap: got %b, required 0", vld0); end
        tick();
        total++; if (vld0 !== 1'b1 || ipc0 !== 32'h80) begin
            bad++; $display("FAIL ma_target: got v=%b pc=%h, required 1/80", vld0, ipc0); end
    endtask

    task automatic test_wrap();
        rv0 = 1'b1; rpc0 = 32'hFFFF_FFFC;
        push(32'hFFFF_FFFC);
        push(32'h0);
        tick();
        total++; if (addr0 !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wr_addr: got %h, required fffffffc", addr0); end
        rv0 = 1'b0;
        tick(); tick();
        total++; if (vld0 !== 1'b1 || ipc0 !== 32'hFFFF_FFFC || addr0 !== 32'h0 || ff0 !== 1'b0) begin
            bad++; $display("FAIL wr_capture: got v=%b pc=%h addr=%h ff=%b, required 1/fffffffc/0/0", vld0, ipc0, addr0, ff0); end
        tick();
        total++; if (vld0 !== 1'b0) begin bad++; $display("FAIL wr_gap: got %b, required 0", vld0); end
        tick();
        total++; if (vld0 !== 1'b1 || ipc0 !== 32'h0 || ins0 !== 32'h0050_0093) begin
            bad++; $display("FAIL wr_zero: got v=%b pc=%h instr=%h, required 1/0/00500093", vld0, ipc0, ins0); end
        tick();
        rdy0 = 1'b0; rst0 = 1'b1; watch8 = 1'b0;
        tick();
        total++; if (seen8 !== 1'b0) begin bad++; $display("FAIL rd_no_pc8: got %b, required 0", seen8); end
        total++; if (exp_pc_q.size() != 0) begin
            bad++; $display("FAIL sb_leftover: got %0d pending, required 0", exp_pc_q.size()); end
    endtask

    task automatic test_memwait1();
        rdy1 = 1'b1; rst1 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [31:0] p;
            p = 32'(k) * 32'd4;
            tick();
            total++; if (vld1 !== 1'b1 || ipc1 !== p || ins1 !== memword(p) || addr1 !== p + 32'd4) begin
                bad++; $display("FAIL mw1_stream: k=%0d got v=%b pc=%h instr=%h addr=%h, required 1/%h/%h/%h",
                                k, vld1, ipc1, ins1, addr1, p, memword(p), p + 32'd4); end
        end
        rdy1 = 1'b0; rst1 = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_reset_fetch();
        test_backpressure();
        test_redirect_flush();
        test_misaligned();
        test_wrap();
        test_memwait1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
